// File: rtl/otn_pkg.sv
// rtl/otn_pkg.sv - shared OTN framing constants and state encodings
// Contents: FAS bytes, CRC-8 polynomial, framer state enum.

package otn_pkg;

    localparam logic [7:0] FAS1_BYTE = 8'hF6;
    localparam logic [7:0] FAS2_BYTE = 8'h28;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAS1,
        ST_FAS2,
        ST_OH,
        ST_PYLD,
        ST_CRC,
        ST_WAIT_ACK
    } frame_state_t;

endpackage

// File: rtl/mapper_framer_if.sv
// rtl/mapper_framer_if.sv - payload, frame and ACK signal bundle of the mapper
// master: framer side (drives o_* signals)
// slave : client / serializer / receiver side (drives i_* signals)

interface mapper_framer_if;

    logic       i_arq_en;
    logic [7:0] i_pyld_data;
    logic       i_pyld_data_valid;
    logic       o_pyld_data_ready;
    logic [7:0] o_frame_data;
    logic       o_frame_data_valid;
    logic       i_frame_data_ready;
    logic       i_ack;
    logic       i_ack_valid;
    logic [7:0] o_crc_val;
    logic       o_drop;

    modport master (
        input  i_arq_en, i_pyld_data, i_pyld_data_valid, i_frame_data_ready,
               i_ack, i_ack_valid,
        output o_pyld_data_ready, o_frame_data, o_frame_data_valid,
               o_crc_val, o_drop
    );

    modport slave (
        output i_arq_en, i_pyld_data, i_pyld_data_valid, i_frame_data_ready,
               i_ack, i_ack_valid,
        input  o_pyld_data_ready, o_frame_data, o_frame_data_valid,
               o_crc_val, o_drop
    );

endinterface

// File: rtl/crc8_byte.sv
// rtl/crc8_byte.sv - combinational byte-wise CRC-8 update (MSB first)
// crc_in  : running CRC
// data    : next byte
// crc_out : CRC after absorbing data

module crc8_byte
    import otn_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    always_comb begin
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/mapper_framer.sv
// rtl/mapper_framer.sv - frames client payload (FAS, OH, payload, CRC-8) with optional ARQ replay
// i_clk, i_rst : clock, synchronous active-high reset
// bus          : payload stream in, frame stream out, ACK verdict in, CRC value and drop pulse out

module mapper_framer
    import otn_pkg::*;
#(
    parameter int PYLD_LEN    = 16,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 100000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    mapper_framer_if.master bus
);

    localparam int IW = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [7:0]    LEN8 = 8'(PYLD_LEN);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    localparam logic [31:0]   TO32 = 32'(ACK_TIMEOUT);

    frame_state_t  state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   tcnt_q, tcnt_d;
    logic [7:0]    crc_acc_q, crc_acc_d;
    logic [7:0]    crc_val_q, crc_val_d;
    logic          arq_q, arq_d;
    logic          replay_q, replay_d;
    logic          drop_q, drop_d;

    logic [7:0]    frame_buf [PYLD_LEN];
    logic          buf_we;
    logic [IW-1:0] buf_waddr;
    logic [7:0]    buf_rd;
    logic [7:0]    pyld_byte;
    logic [7:0]    crc_in, crc_data, crc_out;
    logic          pyld_rdy;
    logic          take;
    logic          accepted;

    // Byte 0 was captured in IDLE, so it always comes from the buffer;
    // in replay every payload byte does.
    assign buf_rd    = frame_buf[cnt_q[IW-1:0]];
    assign pyld_byte = (replay_q || cnt_q == 8'd0) ? buf_rd : bus.i_pyld_data;

    // The CRC starts on the overhead byte (loaded in FAS2) from a zero seed.
    assign crc_in   = (state_q == ST_FAS2) ? 8'h00 : crc_acc_q;
    assign crc_data = (state_q == ST_FAS2) ? {7'b0, arq_q} : pyld_byte;

    crc8_byte u_crc (
        .crc_in  (crc_in),
        .data    (crc_data),
        .crc_out (crc_out)
    );

    // The output register can take a new byte when empty or being drained.
    assign take     = !valid_q || bus.i_frame_data_ready;
    assign accepted = valid_q && bus.i_frame_data_ready;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        tcnt_d    = tcnt_q;
        crc_acc_d = crc_acc_q;
        crc_val_d = crc_val_q;
        arq_d     = arq_q;
        replay_d  = replay_q;
        drop_d    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = cnt_q[IW-1:0];
        pyld_rdy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pyld_rdy = 1'b1;
                if (bus.i_pyld_data_valid) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    data_d    = FAS1_BYTE;
                    valid_d   = 1'b1;
                    arq_d     = bus.i_arq_en;
                    replay_d  = 1'b0;
                    state_d   = ST_FAS1;
                end
            end
            ST_FAS1: if (accepted) begin
                data_d  = FAS2_BYTE;
                state_d = ST_FAS2;
            end
            ST_FAS2: if (accepted) begin
                data_d    = {7'b0, arq_q};
                crc_acc_d = crc_out;
                state_d   = ST_OH;
            end
            ST_OH: if (accepted) begin
                data_d    = pyld_byte;
                crc_acc_d = crc_out;
                cnt_d     = 8'd1;
                state_d   = ST_PYLD;
            end
            ST_PYLD: begin
                if (cnt_q == LEN8) begin
                    if (take) begin
                        data_d  = crc_acc_q;
                        valid_d = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ST_CRC;
                    end
                end else if (replay_q) begin
                    if (take) begin
                        data_d    = pyld_byte;
                        valid_d   = 1'b1;
                        crc_acc_d = crc_out;
                        cnt_d     = cnt_q + 8'd1;
                    end
                end else begin
                    pyld_rdy = take;
                    if (take && bus.i_pyld_data_valid) begin
                        data_d    = pyld_byte;
                        valid_d   = 1'b1;
                        buf_we    = 1'b1;
                        crc_acc_d = crc_out;
                        cnt_d     = cnt_q + 8'd1;
                    end else if (accepted) begin
                        valid_d = 1'b0;
                    end
                end
            end
            ST_CRC: if (accepted) begin
                valid_d   = 1'b0;
                crc_val_d = data_q;
                if (arq_q) begin
                    tcnt_d  = '0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                // A good ACK takes priority over a coincident timeout.
                if (bus.i_ack_valid && bus.i_ack) begin
                    retry_d = '0;
                    state_d = ST_IDLE;
                end else if ((bus.i_ack_valid && !bus.i_ack) || tcnt_q == TO32) begin
                    if (retry_q < RMAX) begin
                        retry_d  = retry_q + RW'(1);
                        replay_d = 1'b1;
                        data_d   = FAS1_BYTE;
                        valid_d  = 1'b1;
                        state_d  = ST_FAS1;
                    end else begin
                        drop_d  = 1'b1;
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            cnt_q     <= 8'd0;
            retry_q   <= '0;
            tcnt_q    <= '0;
            crc_acc_q <= 8'h00;
            crc_val_q <= 8'h00;
            arq_q     <= 1'b0;
            replay_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            tcnt_q    <= tcnt_d;
            crc_acc_q <= crc_acc_d;
            crc_val_q <= crc_val_d;
            arq_q     <= arq_d;
            replay_q  <= replay_d;
            drop_q    <= drop_d;
        end
    end

    // Buffer contents survive reset; only the write enable matters.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            frame_buf[buf_waddr] <= bus.i_pyld_data;
        end
    end

    assign bus.o_pyld_data_ready  = pyld_rdy && !i_rst;
    assign bus.o_frame_data       = data_q;
    assign bus.o_frame_data_valid = valid_q;
    assign bus.o_crc_val          = crc_val_q;
    assign bus.o_drop             = drop_q;

endmodule

// File: tb/tb_mapper_framer.sv
// tb/tb_mapper_framer.sv - directed bench for mapper_framer (PYLD_LEN=9, MAX_RETRY=3, ACK_TIMEOUT=50)

module tb_mapper_framer;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    mapper_framer_if bus();

    mapper_framer #(
        .PYLD_LEN    (9),
        .MAX_RETRY   (3),
        .ACK_TIMEOUT (50)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] src_q[$];
    logic [7:0] out_q[$];
    logic [7:0] exp_f [13];
    int src_acc   = 0;
    int gap_at    = -1;
    int gap_len   = 0;
    int gap_left  = 0;
    int run_len   = 0;
    int max_run   = 0;
    int drop_cnt  = 0;
    int sink_mode = 0;

    // Input driver: changes 1 time unit after the rising edge.
    always @(posedge i_clk) begin
        #1;
        bus.i_frame_data_ready = (sink_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (gap_left > 0) begin
            gap_left--;
            bus.i_pyld_data_valid = 1'b0;
        end else if (src_q.size() > 0) begin
            bus.i_pyld_data_valid = 1'b1;
            bus.i_pyld_data       = src_q[0];
        end else begin
            bus.i_pyld_data_valid = 1'b0;
        end
    end

    // Monitor: samples handshakes mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (bus.i_pyld_data_valid && bus.o_pyld_data_ready) begin
                src_q.delete(0);
                src_acc++;
                if (src_acc == gap_at) begin
                    gap_left = gap_len;
                    gap_at   = -1;
                end
            end
            if (bus.o_frame_data_valid && bus.i_frame_data_ready)
                out_q.push_back(bus.o_frame_data);
            if (bus.o_frame_data_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.o_drop) drop_cnt++;
        end
    end

    task automatic load_payload();
        for (int i = 0; i < 9; i++) src_q.push_back(8'h31 + 8'(i));
    endtask

    task automatic make_exp(input logic [7:0] oh, input logic [7:0] crc);
        exp_f[0]  = 8'hF6;
        exp_f[1]  = 8'h28;
        exp_f[2]  = oh;
        for (int i = 0; i < 9; i++) exp_f[3 + i] = 8'h31 + 8'(i);
        exp_f[12] = crc;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            #1;
            if (out_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_run();
        out_q.delete();
        src_q.delete();
        src_acc  = 0;
        max_run  = 0;
        drop_cnt = 0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #2;
        checks++; if (bus.o_frame_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.o_frame_data_valid); end
        checks++; if (bus.o_pyld_data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.o_pyld_data_ready); end
        checks++; if (bus.o_frame_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", bus.o_frame_data); end
        checks++; if (bus.o_crc_val !== 8'h00) begin errors++; $display("FAIL rst_crc got %h want 00", bus.o_crc_val); end
        checks++; if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", bus.o_drop); end
        i_rst = 1'b0;
        @(posedge i_clk);
        #2;
        checks++; if (bus.o_pyld_data_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", bus.o_pyld_data_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_run();
        sink_mode = 0;
        bus.i_arq_en = 1'b0;
        make_exp(8'h00, 8'hF4);
        load_payload();
        wait_out(13, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_wait got %0d bytes want 13", out_q.size()); end
        @(posedge i_clk);
        #2;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_f[i]) begin
                errors++;
                $display("FAIL basic_byte%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_f[i]);
            end
        end
        checks++; if (bus.o_crc_val !== 8'hF4) begin errors++; $display("FAIL basic_crc got %h want f4", bus.o_crc_val); end
        checks++; if (max_run !== 13) begin errors++; $display("FAIL basic_run got %0d want 13", max_run); end
        checks++; if (src_acc !== 9) begin errors++; $display("FAIL basic_accepted got %0d want 9", src_acc); end
        checks++; if (bus.o_pyld_data_ready !== 1'b1 || bus.o_frame_data_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle got rdy=%b vld=%b want 1/0", bus.o_pyld_data_ready, bus.o_frame_data_valid);
        end
    endtask

    task automatic test_arq_nack_ack();
        bit ok;
        int bad;
        clear_run();
        sink_mode = 0;
        bus.i_arq_en = 1'b1;
        make_exp(8'h01, 8'h9C);
        load_payload();
        wait_out(13, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arq_wait1 got %0d bytes want 13", out_q.size()); end
        @(posedge i_clk);
        #2;
        checks++; if (bus.o_pyld_data_ready !== 1'b0) begin errors++; $display("FAIL arq_wait_ready got %b want 0", bus.o_pyld_data_ready); end
        bus.i_ack_valid = 1'b1; bus.i_ack = 1'b0;
        @(posedge i_clk);
        #1 bus.i_ack_valid = 1'b0;
        wait_out(26, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arq_wait2 got %0d bytes want 26", out_q.size()); end
        @(posedge i_clk);
        #2;
        bus.i_ack_valid = 1'b1; bus.i_ack = 1'b1;
        @(posedge i_clk);
        #1 bus.i_ack_valid = 1'b0;
        #1;
        for (int f = 0; f < 2; f++) begin
            bad = 0;
            for (int i = 0; i < 13; i++)
                if (13 * f + i >= out_q.size() || out_q[13 * f + i] !== exp_f[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL arq_frame%0d got %0d bad bytes want 0", f, bad); end
        end
        checks++; if (bus.o_crc_val !== 8'h9C) begin errors++; $display("FAIL arq_crc got %h want 9c", bus.o_crc_val); end
        checks++; if (src_acc !== 9) begin errors++; $display("FAIL arq_accepted got %0d want 9", src_acc); end
        checks++; if (bus.o_pyld_data_ready !== 1'b1) begin errors++; $display("FAIL arq_idle got %b want 1", bus.o_pyld_data_ready); end
        // A NACK while idle must not start a replay.
        bus.i_ack_valid = 1'b1; bus.i_ack = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 bus.i_ack_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        checks++; if (out_q.size() !== 26 || bus.o_frame_data_valid !== 1'b0) begin
            errors++; $display("FAIL idle_nack got %0d bytes vld=%b want 26/0", out_q.size(), bus.o_frame_data_valid);
        end
    endtask

    task automatic test_drop();
        bit ok;
        int bad;
        clear_run();
        sink_mode = 0;
        bus.i_arq_en = 1'b1;
        make_exp(8'h01, 8'h9C);
        load_payload();
        for (int f = 1; f <= 4; f++) begin
            wait_out(13 * f, 200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL drop_wait%0d got %0d bytes want %0d", f, out_q.size(), 13 * f); end
            @(posedge i_clk);
            #2;
            bus.i_ack_valid = 1'b1; bus.i_ack = 1'b0;
            @(posedge i_clk);
            #1 bus.i_ack_valid = 1'b0;
        end
        #1;
        checks++; if (bus.o_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", bus.o_drop); end
        @(posedge i_clk);
        #2;
        checks++; if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL drop_end got %b want 0", bus.o_drop); end
        repeat (20) @(posedge i_clk);
        #2;
        checks++; if (out_q.size() !== 52) begin errors++; $display("FAIL drop_bytes got %0d want 52", out_q.size()); end
        checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL drop_count got %0d want 1", drop_cnt); end
        checks++; if (bus.o_pyld_data_ready !== 1'b1) begin errors++; $display("FAIL drop_idle got %b want 1", bus.o_pyld_data_ready); end
        bad = 0;
        for (int i = 0; i < 52; i++)
            if (i >= out_q.size() || out_q[i] !== exp_f[i % 13]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL drop_frames got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        int bad;
        clear_run();
        sink_mode = 0;
        bus.i_arq_en = 1'b1;
        make_exp(8'h01, 8'h9C);
        load_payload();
        wait_out(13, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_wait1 got %0d bytes want 13", out_q.size()); end
        @(posedge i_clk);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge i_clk);
            k++;
            #1;
            if (bus.o_frame_data_valid) break;
        end
        checks++; if (k !== 51) begin errors++; $display("FAIL to_latency got %0d want 51", k); end
        checks++; if (bus.o_frame_data !== 8'hF6) begin errors++; $display("FAIL to_fas got %h want f6", bus.o_frame_data); end
        wait_out(26, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_wait2 got %0d bytes want 26", out_q.size()); end
        // ACK lands on the very cycle the timeout expires.
        @(posedge i_clk);
        repeat (50) @(posedge i_clk);
        #1;
        bus.i_ack_valid = 1'b1; bus.i_ack = 1'b1;
        @(posedge i_clk);
        #1 bus.i_ack_valid = 1'b0;
        #1;
        checks++; if (bus.o_frame_data_valid !== 1'b0 || bus.o_pyld_data_ready !== 1'b1) begin
            errors++; $display("FAIL ack_wins got vld=%b rdy=%b want 0/1", bus.o_frame_data_valid, bus.o_pyld_data_ready);
        end
        repeat (5) @(posedge i_clk);
        #2;
        checks++; if (out_q.size() !== 26) begin errors++; $display("FAIL ack_wins_bytes got %0d want 26", out_q.size()); end
        bad = 0;
        for (int i = 0; i < 26; i++)
            if (i >= out_q.size() || out_q[i] !== exp_f[i % 13]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL to_frames got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        clear_run();
        bus.i_arq_en = 1'b0;
        sink_mode = 1;
        gap_at    = 4;
        gap_len   = 5;
        make_exp(8'h00, 8'hF4);
        load_payload();
        wait_out(13, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_wait got %0d bytes want 13", out_q.size()); end
        @(posedge i_clk);
        #2;
        sink_mode = 0;
        repeat (3) @(posedge i_clk);
        #2;
        bad = 0;
        for (int i = 0; i < 13; i++)
            if (i >= out_q.size() || out_q[i] !== exp_f[i]) bad++;
        checks++; if (bad != 0 || out_q.size() !== 13) begin errors++; $display("FAIL bp_frame got %0d bad of %0d bytes want 0 of 13", bad, out_q.size()); end
        checks++; if (bus.o_crc_val !== 8'hF4) begin errors++; $display("FAIL bp_crc got %h want f4", bus.o_crc_val); end
        checks++; if (src_acc !== 9) begin errors++; $display("FAIL bp_accepted got %0d want 9", src_acc); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        clear_run();
        sink_mode = 0;
        bus.i_arq_en = 1'b0;
        make_exp(8'h00, 8'hF4);
        load_payload();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            #1;
            if (src_acc >= 5) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_wait got %0d accepted want 5", src_acc); end
        i_rst = 1'b1;
        @(posedge i_clk);
        #2;
        checks++; if (bus.o_frame_data_valid !== 1'b0 || bus.o_pyld_data_ready !== 1'b0 || bus.o_frame_data !== 8'h00
                      || bus.o_crc_val !== 8'h00 || bus.o_drop !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got vld=%b rdy=%b data=%h crc=%h drop=%b want 0/0/00/00/0", bus.o_frame_data_valid,
                     bus.o_pyld_data_ready, bus.o_frame_data, bus.o_crc_val, bus.o_drop);
        end
        clear_run();
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        load_payload();
        wait_out(13, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_wait2 got %0d bytes want 13", out_q.size()); end
        @(posedge i_clk);
        #2;
        bad = 0;
        for (int i = 0; i < 13; i++)
            if (i >= out_q.size() || out_q[i] !== exp_f[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_frame got %0d bad bytes want 0", bad); end
        checks++; if (bus.o_crc_val !== 8'hF4) begin errors++; $display("FAIL mid_crc got %h want f4", bus.o_crc_val); end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
    endtask

    initial begin
        bus.i_arq_en           = 1'b0;
        bus.i_pyld_data        = 8'h00;
        bus.i_pyld_data_valid  = 1'b0;
        bus.i_frame_data_ready = 1'b1;
        bus.i_ack              = 1'b0;
        bus.i_ack_valid        = 1'b0;
        test_reset();
        test_basic();
        test_arq_nack_ack();
        test_drop();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
